timer6502: RTL

Memory-mapped programmable interval timer that sits on the cpu6502 bus as a responder, alongside ROM/RAM. The CPU reads and writes its registers through the address/data/rw bus, qualified by phi2 (`clk2`). The timer drives the CPU's `irq` input. The block decodes its own address window and exposes `sel` so the top level can mux `rdata` onto the CPU's `idata`.

---
 rtl/timer6502.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/timer6502.sv
// Programmable interval timer on the cpu6502 bus: 16-bit reload counter,
// 8-bit prescaler, one-shot/continuous modes and an active-low level irq.
//
// state | meaning
// STOP  | count and prescaler frozen
// RUN   | prescaler advancing, count decrementing on each tick
module timer6502 #(
    parameter logic [15:0] BASE = 16'hD000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rw,
    input  logic        clk2,
    output logic [7:0]  rdata,
    output logic        sel,
    output logic        irq
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        clk2_d;
    logic [15:0] count;
    logic [15:0] reload;
    logic [7:0]  hi_shadow;
    logic [7:0]  presc;
    logic [7:0]  pcnt;
    logic        en;
    logic        ie;
    logic        oneshot;
    logic        flag;

    logic [2:0]  off;
    logic        stb;
    logic        wr;
    logic        rd;
    logic        wr_lo;
    logic        wr_hi;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        wr_presc;
    logic        rd_lo;
    logic        tick;
    logic        expire;

    assign sel      = (addr[15:3] == BASE[15:3]);
    assign off      = addr[2:0];
    assign stb      = clk2 & ~clk2_d & sel;
    assign wr       = stb & ~rw;
    assign rd       = stb & rw;
    assign wr_lo    = wr & (off == 3'd0);
    assign wr_hi    = wr & (off == 3'd1);
    assign wr_ctrl  = wr & (off == 3'd2);
    assign wr_stat  = wr & (off == 3'd3);
    assign wr_presc = wr & (off == 3'd4);
    assign rd_lo    = rd & (off == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if ((state == ST_RUN) && expire && oneshot) begin
            state_nx = ST_STOP;
        end
        // A CTRL write overrides a same-edge one-shot stop.
        if (wr_ctrl) begin
            state_nx = wdata[0] ? ST_RUN : ST_STOP;
        end else if (wr_hi && en) begin
            state_nx = ST_RUN;
        end
    end

    // A CNT_HI write restarts the period, so any tick on that edge is dropped.
    always_comb begin
        tick   = 1'b0;
        expire = 1'b0;
        if (state == ST_RUN) begin
            tick   = (pcnt == presc) & ~wr_hi;
            expire = tick & (count == 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk2_d    <= 1'b0;
            count     <= 16'h0000;
            reload    <= 16'h0000;
            hi_shadow <= 8'h00;
            presc     <= 8'h00;
            pcnt      <= 8'h00;
            en        <= 1'b0;
            ie        <= 1'b0;
            oneshot   <= 1'b0;
            flag      <= 1'b0;
        end else begin
            clk2_d <= clk2;

            if (wr_lo) begin
                reload[7:0] <= wdata;
            end
            if (wr_hi) begin
                reload[15:8] <= wdata;
            end
            if (wr_presc) begin
                presc <= wdata;
            end
            if (rd_lo) begin
                hi_shadow <= count[15:8];
            end

            if (wr_hi) begin
                pcnt <= 8'h00;
            end else if (state == ST_RUN) begin
                pcnt <= (pcnt == presc) ? 8'h00 : pcnt + 8'd1;
            end

            if (wr_hi) begin
                count <= {wdata, reload[7:0]};
            end else if (expire) begin
                count <= reload;
            end else if (tick) begin
                count <= count - 16'd1;
            end

            if (expire) begin
                flag <= 1'b1;
            end else if (wr_stat && wdata[0]) begin
                flag <= 1'b0;
            end

            if (wr_ctrl) begin
                en      <= wdata[0];
                ie      <= wdata[1];
                oneshot <= wdata[2];
            end else if (expire && oneshot) begin
                en <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (off)
                3'd0:    rdata = count[7:0];
                3'd1:    rdata = hi_shadow;
                3'd2:    rdata = {5'b00000, oneshot, ie, en};
                3'd3:    rdata = {7'b0000000, flag};
                3'd4:    rdata = presc;
                default: rdata = 8'h00;
            endcase
        end
    end

    assign irq = ~(flag & ie);

endmodule
